// File: rtl/output_queue_pkg.sv
// Shared constants and payload types for the output arbiter and the output queue.
package output_queue_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned PRIO_W = 4;

  localparam logic [PRIO_W-1:0] PRIO_ONE   = 4'b0001;
  localparam logic [PRIO_W-1:0] PRIO_TWO   = 4'b0010;
  localparam logic [PRIO_W-1:0] PRIO_THREE = 4'b0100;
  localparam logic [PRIO_W-1:0] PRIO_FOUR  = 4'b1000;
  localparam logic [PRIO_W-1:0] PRIO_RST   = PRIO_ONE;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/output_fifo.sv
// Storage, pointers and occupancy count for the output queue.
module output_fifo
  import output_queue_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  entry_t wr_entry,
  input  logic   rd_req,
  output logic   full,
  output logic   valid,
  output entry_t head
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_req && valid;

  // Head is a pure mux of registers; forced to zero while empty so reset reads clean.
  assign head = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_ok)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/output_queue.sv
// Output queue: grant mux into a small FIFO plus the arbiter's rotating priority.
module output_queue
  import output_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              granttoone,
  input  logic              granttotwo,
  input  logic              granttothree,
  input  logic              granttofour,
  input  logic              change_prio,
  input  logic [DATA_W-1:0] dataone,
  input  logic [DATA_W-1:0] datatwo,
  input  logic [DATA_W-1:0] datathree,
  input  logic [DATA_W-1:0] datafour,
  input  logic              out_ready,
  output logic              isfull,
  output logic [PRIO_W-1:0] priority_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SRC_W-1:0]  out_src,
  output logic              err_overflow
);

  logic [3:0]        grant;
  logic              grant_ok;
  logic              wr_en;
  entry_t            wr_entry;
  entry_t            head;
  logic [PRIO_W-1:0] prio_nxt;

  assign grant    = {granttofour, granttothree, granttotwo, granttoone};
  assign grant_ok = is_onehot4(grant);
  assign wr_en    = grant_ok && !isfull;

  always_comb begin
    wr_entry = '0;
    case (grant)
      4'b0001: wr_entry = '{src: SRC_W'(0), data: dataone};
      4'b0010: wr_entry = '{src: SRC_W'(1), data: datatwo};
      4'b0100: wr_entry = '{src: SRC_W'(2), data: datathree};
      4'b1000: wr_entry = '{src: SRC_W'(3), data: datafour};
      default: wr_entry = '0;
    endcase
  end

  output_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .rd_req   (out_ready),
    .full     (isfull),
    .valid    (out_valid),
    .head     (head)
  );

  assign out_data = head.data;
  assign out_src  = head.src;

  // Any grant against a full queue, or a multi-hot grant, is an illegal write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_overflow <= 1'b0;
    else if ((grant != 4'd0) && (isfull || !grant_ok))
      err_overflow <= 1'b1;
  end

  // Rotate left on request; a corrupted non-one-hot value falls back to the reset priority.
  always_comb begin
    prio_nxt = priority_val;
    if (!is_onehot4(priority_val))
      prio_nxt = PRIO_RST;
    else if (change_prio)
      prio_nxt = {priority_val[PRIO_W-2:0], priority_val[PRIO_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      priority_val <= PRIO_RST;
    else
      priority_val <= prio_nxt;
  end

endmodule

// File: tb/tb_output_queue.sv
// Self-checking bench for output_queue: directed scenarios plus a randomized run against a queue model.
module tb_output_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] g = 4'd0;
  logic [7:0] d [4];
  logic       cp = 1'b0;
  logic       rdy = 1'b0;
  logic       isfull;
  logic [3:0] priority_val;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {logic [1:0] src; logic [7:0] data;} m_t;
  m_t         mq[$];
  bit         m_err;
  logic [3:0] m_prio;

  always #5 clk = ~clk;

  output_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .granttoone   (g[0]),
    .granttotwo   (g[1]),
    .granttothree (g[2]),
    .granttofour  (g[3]),
    .change_prio  (cp),
    .dataone      (d[0]),
    .datatwo      (d[1]),
    .datathree    (d[2]),
    .datafour     (d[3]),
    .out_ready    (rdy),
    .isfull       (isfull),
    .priority_val (priority_val),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_src      (out_src),
    .err_overflow (err_overflow)
  );

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // One clock: inputs already set at the falling edge, model follows the queue rules.
  task automatic tick();
    int  n;
    bit  full, rd, wr;
    m_t  e;
    @(posedge clk);
    n    = popc(g);
    full = (mq.size() == 4);
    if (n > 1 || (n == 1 && full)) m_err = 1;
    rd = (mq.size() > 0) && rdy;
    wr = (n == 1) && !full;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (g[i]) begin e.src = 2'(i); e.data = d[i]; end
      mq.push_back(e);
    end
    if (cp) m_prio = {m_prio[2:0], m_prio[3]};
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    g = 4'd0; cp = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_err = 0; m_prio = 4'b0001;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (isfull !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", isfull); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", out_src); end
    n_checks++; if (priority_val !== 4'b0001) begin n_fail++; $display("FAIL reset_prio got %b exp 0001", priority_val); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_overflow); end
    rst_n = 1'b1;
    mq.delete(); m_err = 0; m_prio = 4'b0001;
  endtask

  task automatic test_single_write();
    g = 4'b0010; d[1] = 8'hA5;
    tick();
    g = 4'd0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", out_data); end
    n_checks++; if (out_src !== 2'd1) begin n_fail++; $display("FAIL single_src got %0d exp 1", out_src); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (isfull !== 1'b0) begin n_fail++; $display("FAIL fill_notfull_%0d got %b exp 0", i, isfull); end
      g = 4'b0001; d[0] = vals[i];
      tick();
    end
    g = 4'd0;
    n_checks++; if (isfull !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", isfull); end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data !== vals[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_%0d got %h/%b exp %h/1", i, out_data, out_valid, vals[i]); end
      tick();
    end
    rdy = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || isfull !== 1'b0) begin n_fail++; $display("FAIL empty_read got %b/%b exp 0/0", out_valid, isfull); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4];
    vals[0] = 8'hC0; vals[1] = 8'hC1; vals[2] = 8'hC2; vals[3] = 8'hC3;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      g = 4'(1 << i); d[i] = vals[i];
      tick();
    end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b exp 0", err_overflow); end
    g = 4'b0001; d[0] = 8'hEE;
    tick();
    g = 4'd0;
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", err_overflow); end
    // Full with a read in the same cycle still drops the grant.
    g = 4'b0100; d[2] = 8'hDD; rdy = 1'b1;
    tick();
    g = 4'd0;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (out_data !== vals[i] || out_src !== 2'(i)) begin n_fail++; $display("FAIL ovf_keep_%0d got %h/%0d exp %h/%0d", i, out_data, out_src, vals[i], i); end
      tick();
    end
    rdy = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end got %b/%b exp 0/1", out_valid, err_overflow); end
  endtask

  task automatic test_back_to_back();
    int drained;
    apply_reset();
    g = 4'b1000; d[3] = 8'h01; tick();
    d[3] = 8'h02; tick();
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1 || isfull !== 1'b0 || out_data !== mq[0].data) begin n_fail++; $display("FAIL b2b_%0d got %h/%b/%b exp %h/1/0", i, out_data, out_valid, isfull, mq[0].data); end
      d[3] = 8'(8'h10 + i);
      tick();
    end
    g = 4'd0;
    drained = 0;
    for (int i = 0; i < 8 && out_valid === 1'b1; i++) begin
      n_checks++; if (out_data !== mq[0].data) begin n_fail++; $display("FAIL b2b_drain_%0d got %h exp %h", i, out_data, mq[0].data); end
      drained++;
      tick();
    end
    rdy = 1'b0;
    n_checks++; if (drained != 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", drained); end
  endtask

  task automatic test_prio();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000;
    exp_seq[3] = 4'b0001; exp_seq[4] = 4'b0010;
    apply_reset();
    n_checks++; if (priority_val !== 4'b0001) begin n_fail++; $display("FAIL prio_init got %b exp 0001", priority_val); end
    for (int i = 0; i < 5; i++) begin
      cp = 1'b1;
      if (i == 2) begin g = 4'b0001; d[0] = 8'h77; end
      tick();
      cp = 1'b0; g = 4'd0;
      tick();
      n_checks++; if (priority_val !== exp_seq[i]) begin n_fail++; $display("FAIL prio_%0d got %b exp %b", i, priority_val, exp_seq[i]); end
    end
    n_checks++; if (out_data !== 8'h77 || out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_write got %h/%b exp 77/1", out_data, out_valid); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      g = 4'b0001; d[0] = 8'(8'h30 + i); cp = 1'b1;
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || priority_val !== 4'b0001) begin n_fail++; $display("FAIL midrst got %b/%b exp 0/0001", out_valid, priority_val); end
    n_checks++; if (out_data !== 8'h00 || out_src !== 2'd0 || isfull !== 1'b0) begin n_fail++; $display("FAIL midrst_out got %h/%0d/%b exp 00/0/0", out_data, out_src, isfull); end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_err = 0; m_prio = 4'b0001;
    g = 4'b0100; d[2] = 8'h5A;
    tick();
    g = 4'd0;
    n_checks++; if (out_data !== 8'h5A || out_src !== 2'd2) begin n_fail++; $display("FAIL midrst_wr got %h/%0d exp 5a/2", out_data, out_src); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_single got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] ed;
    logic [1:0] es;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      ed = (mq.size() > 0) ? mq[0].data : 8'h00;
      es = (mq.size() > 0) ? mq[0].src : 2'd0;
      n_checks++;
      if (out_valid !== (mq.size() > 0) || isfull !== (mq.size() == 4) || out_data !== ed ||
          out_src !== es || priority_val !== m_prio || err_overflow !== m_err) begin
        n_fail++;
        $display("FAIL rand_%0d got v%b f%b d%h s%0d p%b e%b exp v%b f%b d%h s%0d p%b e%b", c,
                 out_valid, isfull, out_data, out_src, priority_val, err_overflow,
                 mq.size() > 0, mq.size() == 4, ed, es, m_prio, m_err);
      end
      r = $urandom_range(0, 9);
      if (r < 4) g = 4'(1 << r);
      else if (r == 9 && c > 300) g = 4'($urandom_range(0, 15));
      else g = 4'd0;
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      rdy = ($urandom_range(0, 9) < 4);
      cp  = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_prio = 4'b0001;
    test_reset();
    test_single_write();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_prio();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_queue.md
OUTPUT_QUEUE -- requirements
Module: output_queue

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Ports granttoone, granttotwo, granttothree, granttofour, inputs, 1 bit each: write grants from the output arbiter; one-hot or zero.
REQ-005 Port change_prio, input, 1 bit: the arbiter's request to rotate priority.
REQ-006 Ports dataone, datatwo, datathree, datafour, inputs, DATA_W bits each: payload from requesters one to four.
REQ-007 Port out_ready, input, 1 bit: the downstream consumer accepts out_data this cycle.
REQ-008 Port isfull, output, 1 bit: queue holds DEPTH entries; fed back to the arbiter.
REQ-009 Port priority_val, output, 4 bits: one-hot priority to the arbiter (0001=one, 0010=two, 0100=three, 1000=four).
REQ-010 Port out_valid, output, 1 bit: queue non-empty; out_data is valid.
REQ-011 Port out_data, output, DATA_W bits: head-of-queue payload.
REQ-012 Port out_src, output, 2 bits: source port of the head entry (0=one … 3=four).
REQ-013 Port err_overflow, output, 1 bit: sticky flag for an illegal write.

Function
REQ-014 Parameters: DATA_W = 8, DEPTH = 4; count width is clog2(DEPTH)+1.
REQ-015 Write: when exactly one grant is high and isfull = 0, the queue SHALL store the selected port's data plus source index at wr_ptr on that edge.
REQ-016 Read: when out_valid = 1 and out_ready = 1, the queue SHALL advance rd_ptr on that edge.
REQ-017 out_valid, out_data and out_src SHALL be driven from registered state, with no combinational path from any input.
REQ-018 Latency: data written at edge N SHALL appear on out_data after edge N if the queue was empty at edge N.
REQ-019 Pointers SHALL wrap DEPTH-1 -> 0; count SHALL range 0..DEPTH.
REQ-020 isfull SHALL equal (count == DEPTH); out_valid SHALL equal (count != 0).
REQ-021 On a simultaneous write and read, count SHALL be unchanged and both pointers SHALL advance; this holds at every count where both are legal.
REQ-022 Empty: out_ready with out_valid = 0 SHALL be ignored, with no pointer change.
REQ-023 If a grant arrives while isfull = 1, or more than one grant is high, the write SHALL be dropped, state SHALL be unchanged, and err_overflow SHALL set and stay high until reset.
REQ-024 Full with a read in the same cycle: a grant SHALL still be dropped, because isfull is sampled from registered count.
REQ-025 Priority rotation: on each edge with change_prio = 1, priority_val SHALL rotate left: 0001->0010->0100->1000->0001.
REQ-026 Rotation SHALL be independent of the queue state.
REQ-027 priority_val SHALL always be one-hot; any non-one-hot value (unreachable) SHALL recover to 0001 on the next edge.
REQ-028 Priority update and data write in the same cycle SHALL both take effect.

Reset
REQ-029 On rst_n = 0, asynchronously: wr_ptr = 0, rd_ptr = 0, count = 0, priority_val = 4'b0001, err_overflow = 0.
REQ-030 During reset, outputs SHALL read isfull = 0, out_valid = 0, out_src = 0, out_data = 0.
REQ-031 Storage array contents need not be reset.
REQ-032 A reset asserted mid-operation SHALL discard all entries; the first write after release SHALL land at entry 0.

Structure
REQ-033 DATA_W, DEPTH and the one-hot priority constants (PRIO_ONE..PRIO_FOUR, reset value) SHALL live in a shared package used by the arbiter and this block.
REQ-034 The storage and pointer logic SHALL be one sub-module, output_fifo; the grant mux and priority rotator SHALL stay in output_queue.

Verification
REQ-035 Reset, then granttotwo=1 with datatwo=8'hA5 for one cycle -> next cycle: out_valid=1, out_data=A5, out_src=1.
REQ-036 Four writes of 11, 22, 33, 44 with out_ready=0 -> isfull=1 after the 4th edge; draining gives 11, 22, 33, 44 in order, then out_valid=0.
REQ-037 Full queue, granttoone=1 -> write dropped, err_overflow=1, contents unchanged.
REQ-038 Two entries plus simultaneous write and read for 10 cycles -> count stays 2 with correct FIFO order across pointer wrap.
REQ-039 change_prio pulsed 5 times from reset -> priority_val sequence 0001, 0010, 0100, 1000, 0001, 0010.
REQ-040 rst_n pulsed low with 3 entries queued -> out_valid=0 and priority_val=0001 immediately; the next write of 5A reads back as 5A.
